// File: rtl/bitmap_tensor_pkg.sv
// Shared constants for the colour-channel interleaver: item width default,
// channel indices and the group FSM encoding.
package bitmap_tensor_pkg;
  localparam int ITEM_WIDTH_DEF = 8;
  localparam int NUM_CH         = 3;
  localparam int CH_RED         = 0;
  localparam int CH_GREEN       = 1;
  localparam int CH_BLUE        = 2;

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_t;
endpackage

// File: rtl/interleave_channel_slot.sv
// One input channel: accepts a single beat per group, holds it until the
// group is emitted, and reports how many contiguous items it carried.
module interleave_channel_slot
  import bitmap_tensor_pkg::*;
#(
  parameter int TDATA_WIDTH = 256,
  parameter int TKEEP_WIDTH = TDATA_WIDTH / 8,
  parameter int ITEM_WIDTH  = ITEM_WIDTH_DEF,
  localparam int ITEM_COUNT    = TDATA_WIDTH / ITEM_WIDTH,
  localparam int KEEP_PER_ITEM = ITEM_WIDTH / 8,
  localparam int N_W           = $clog2(ITEM_COUNT + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   collect,
  input  logic                   clear,
  input  logic [TDATA_WIDTH-1:0] tdata,
  input  logic [TKEEP_WIDTH-1:0] tkeep,
  input  logic                   tvalid,
  input  logic                   tlast,
  output logic                   tready,
  output logic                   held,
  output logic [TDATA_WIDTH-1:0] data,
  output logic                   last,
  output logic [N_W-1:0]         n
);
  logic [N_W-1:0] n_in;
  logic           run;

  // Reset gates ready so the upstream sees 0 for the whole reset interval.
  assign tready = rst_n & collect & ~held;

  // Count of fully-kept items from the LSB; stops at the first hole.
  always_comb begin
    n_in = '0;
    run  = 1'b1;
    for (int i = 0; i < ITEM_COUNT; i++) begin
      if (run && (&tkeep[i*KEEP_PER_ITEM +: KEEP_PER_ITEM])) n_in = n_in + N_W'(1);
      else run = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held <= 1'b0;
      data <= '0;
      last <= 1'b0;
      n    <= '0;
    end else if (tvalid && tready) begin
      held <= 1'b1;
      data <= tdata;
      last <= tlast;
      n    <= n_in;
    end else if (clear) begin
      held <= 1'b0;
    end
  end
endmodule

// File: rtl/interleave_color_channels.sv
// Collects one beat from each of red/green/blue, then emits the items
// interleaved R,G,B,R,G,B... over as many output beats as needed.
module interleave_color_channels
  import bitmap_tensor_pkg::*;
#(
  parameter int TDATA_WIDTH = 256,
  parameter int TKEEP_WIDTH = TDATA_WIDTH / 8,
  parameter int TUSER_WIDTH = 128,
  parameter int ITEM_WIDTH  = ITEM_WIDTH_DEF
) (
  input  logic                   axis_aclk,
  input  logic                   axis_resetn,
  input  logic [TDATA_WIDTH-1:0] red_tdata,
  input  logic [TKEEP_WIDTH-1:0] red_tkeep,
  input  logic [TUSER_WIDTH-1:0] red_tuser,
  input  logic                   red_tvalid,
  output logic                   red_tready,
  input  logic                   red_tlast,
  input  logic [TDATA_WIDTH-1:0] green_tdata,
  input  logic [TKEEP_WIDTH-1:0] green_tkeep,
  input  logic [TUSER_WIDTH-1:0] green_tuser,
  input  logic                   green_tvalid,
  output logic                   green_tready,
  input  logic                   green_tlast,
  input  logic [TDATA_WIDTH-1:0] blue_tdata,
  input  logic [TKEEP_WIDTH-1:0] blue_tkeep,
  input  logic [TUSER_WIDTH-1:0] blue_tuser,
  input  logic                   blue_tvalid,
  output logic                   blue_tready,
  input  logic                   blue_tlast,
  output logic [TDATA_WIDTH-1:0] rgb_tdata,
  output logic [TKEEP_WIDTH-1:0] rgb_tkeep,
  output logic [TUSER_WIDTH-1:0] rgb_tuser,
  output logic                   rgb_tvalid,
  input  logic                   rgb_tready,
  output logic                   rgb_tlast,
  output logic                   channel_mismatch
);
  localparam int ITEM_COUNT    = TDATA_WIDTH / ITEM_WIDTH;
  localparam int KEEP_PER_ITEM = ITEM_WIDTH / 8;
  localparam int N_W           = $clog2(ITEM_COUNT + 1);
  localparam int IDX_W         = $clog2(3 * ITEM_COUNT) + 1;

  logic [TDATA_WIDTH-1:0] in_data [NUM_CH];
  logic [TKEEP_WIDTH-1:0] in_keep [NUM_CH];
  logic [TDATA_WIDTH-1:0] ch_data [NUM_CH];
  logic [N_W-1:0]         ch_n    [NUM_CH];
  logic [NUM_CH-1:0]      in_valid, in_last, ch_ready, ch_held, ch_last, ch_hs;

  state_t                 state, state_nx;
  logic [1:0]             beat_cnt, beat_cnt_nx, beats_m1;
  logic                   grp_done, last_beat, collect;
  logic [IDX_W-1:0]       total;
  logic [TUSER_WIDTH-1:0] user_q;
  logic                   unused_sideband;

  assign in_data[CH_RED]   = red_tdata;
  assign in_data[CH_GREEN] = green_tdata;
  assign in_data[CH_BLUE]  = blue_tdata;
  assign in_keep[CH_RED]   = red_tkeep;
  assign in_keep[CH_GREEN] = green_tkeep;
  assign in_keep[CH_BLUE]  = blue_tkeep;
  assign in_valid = {blue_tvalid, green_tvalid, red_tvalid};
  assign in_last  = {blue_tlast, green_tlast, red_tlast};
  assign {blue_tready, green_tready, red_tready} = ch_ready;
  assign ch_hs    = in_valid & ch_ready;
  assign collect  = (state == COLLECT);

  // Only red's sideband is forwarded.
  assign unused_sideband = ^{green_tuser, blue_tuser};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_slot
    interleave_channel_slot #(
      .TDATA_WIDTH(TDATA_WIDTH),
      .TKEEP_WIDTH(TKEEP_WIDTH),
      .ITEM_WIDTH (ITEM_WIDTH)
    ) u_slot (
      .clk   (axis_aclk),
      .rst_n (axis_resetn),
      .collect(collect),
      .clear (grp_done),
      .tdata (in_data[c]),
      .tkeep (in_keep[c]),
      .tvalid(in_valid[c]),
      .tlast (in_last[c]),
      .tready(ch_ready[c]),
      .held  (ch_held[c]),
      .data  (ch_data[c]),
      .last  (ch_last[c]),
      .n     (ch_n[c])
    );
  end

  // Red's item count governs the group regardless of the other channels.
  assign total     = IDX_W'(3) * IDX_W'(ch_n[CH_RED]);
  assign beats_m1  = (total == '0) ? 2'd0 : 2'((total - IDX_W'(1)) / IDX_W'(ITEM_COUNT));
  assign last_beat = (beat_cnt == beats_m1);

  // Entering EMIT on the last capture's edge makes tvalid follow it by one cycle.
  always_comb begin
    state_nx    = state;
    beat_cnt_nx = beat_cnt;
    grp_done    = 1'b0;
    case (state)
      COLLECT: if (&(ch_held | ch_hs)) begin
        state_nx    = EMIT;
        beat_cnt_nx = '0;
      end
      EMIT: if (rgb_tready) begin
        if (last_beat) begin
          state_nx    = COLLECT;
          beat_cnt_nx = '0;
          grp_done    = 1'b1;
        end else begin
          beat_cnt_nx = beat_cnt + 2'd1;
        end
      end
      default: state_nx = COLLECT;
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state    <= COLLECT;
      beat_cnt <= '0;
    end else begin
      state    <= state_nx;
      beat_cnt <= beat_cnt_nx;
    end
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn)   user_q <= '0;
    else if (ch_hs[CH_RED]) user_q <= red_tuser;
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) channel_mismatch <= 1'b0;
    else if (state == EMIT &&
             ((ch_n[CH_GREEN] != ch_n[CH_RED]) || (ch_n[CH_BLUE] != ch_n[CH_RED]) ||
              !((&ch_last) || !(|ch_last))))
      channel_mismatch <= 1'b1;
  end

  assign rgb_tvalid = (state == EMIT);
  assign rgb_tlast  = (state == EMIT) && last_beat && ch_last[CH_RED];
  assign rgb_tuser  = user_q;

  // Output item i = beat*ITEM_COUNT + lane is item i/3 of channel i%3.
  for (genvar l = 0; l < ITEM_COUNT; l++) begin : g_lane
    logic [IDX_W-1:0]       idx, item;
    logic [1:0]             ch;
    logic                   vld;
    logic [TDATA_WIDTH-1:0] src;

    assign idx  = IDX_W'(beat_cnt) * IDX_W'(ITEM_COUNT) + IDX_W'(l);
    assign ch   = 2'(idx % IDX_W'(3));
    assign item = idx / IDX_W'(3);
    assign vld  = (idx < total);

    always_comb begin
      case (ch)
        2'd0:    src = ch_data[CH_RED];
        2'd1:    src = ch_data[CH_GREEN];
        default: src = ch_data[CH_BLUE];
      endcase
    end

    assign rgb_tdata[l*ITEM_WIDTH +: ITEM_WIDTH] =
      vld ? ITEM_WIDTH'(src >> (32'(item) * ITEM_WIDTH)) : '0;
    assign rgb_tkeep[l*KEEP_PER_ITEM +: KEEP_PER_ITEM] = {KEEP_PER_ITEM{vld}};
  end
endmodule

// File: tb/tb_interleave_color_channels.sv
// Directed table-driven bench for interleave_color_channels at default widths.
module tb_interleave_color_channels;
  localparam int TDW = 256;
  localparam int TKW = 32;
  localparam int TUW = 128;
  localparam int IC  = 32;

  logic           axis_aclk = 1'b0;
  logic           axis_resetn = 1'b0;
  logic [TDW-1:0] red_tdata, green_tdata, blue_tdata, rgb_tdata;
  logic [TKW-1:0] red_tkeep, green_tkeep, blue_tkeep, rgb_tkeep;
  logic [TUW-1:0] red_tuser, green_tuser, blue_tuser, rgb_tuser;
  logic           red_tvalid, green_tvalid, blue_tvalid, rgb_tvalid;
  logic           red_tready, green_tready, blue_tready, rgb_tready;
  logic           red_tlast, green_tlast, blue_tlast, rgb_tlast;
  logic           channel_mismatch;

  interleave_color_channels dut (
    .axis_aclk(axis_aclk), .axis_resetn(axis_resetn),
    .red_tdata(red_tdata), .red_tkeep(red_tkeep), .red_tuser(red_tuser),
    .red_tvalid(red_tvalid), .red_tready(red_tready), .red_tlast(red_tlast),
    .green_tdata(green_tdata), .green_tkeep(green_tkeep), .green_tuser(green_tuser),
    .green_tvalid(green_tvalid), .green_tready(green_tready), .green_tlast(green_tlast),
    .blue_tdata(blue_tdata), .blue_tkeep(blue_tkeep), .blue_tuser(blue_tuser),
    .blue_tvalid(blue_tvalid), .blue_tready(blue_tready), .blue_tlast(blue_tlast),
    .rgb_tdata(rgb_tdata), .rgb_tkeep(rgb_tkeep), .rgb_tuser(rgb_tuser),
    .rgb_tvalid(rgb_tvalid), .rgb_tready(rgb_tready), .rgb_tlast(rgb_tlast),
    .channel_mismatch(channel_mismatch)
  );

  always #5 axis_aclk = ~axis_aclk;

  typedef struct {
    logic [31:0] keep_r, keep_g, keep_b;
    logic        last_r, last_g, last_b;
    int          gdelay, bp_beat, n, beats;
    logic [31:0] keep_final;
    logic        tlast, mm;
  } vec_t;

  vec_t tbl[7];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] src_byte(input int ch, input int k);
    return 8'(ch * 64 + k);
  endfunction

  function automatic logic [TUW-1:0] user_of(input int gi);
    return TUW'(gi + 1) * 128'h0001_0000_0000_0000_0000_0000_0001_0001;
  endfunction

  task automatic exp_beat(input int n, input int b, output logic [255:0] d, output logic [31:0] k);
    d = '0;
    k = '0;
    for (int l = 0; l < IC; l++) begin
      int i;
      i = b * IC + l;
      if (i < 3 * n) begin
        d = d | (256'(src_byte(i % 3, i / 3)) << (l * 8));
        k[l] = 1'b1;
      end
    end
  endtask

  task automatic send_group(input vec_t v, input int gi);
    bit dr = 0, dg = 0, db = 0, hr, hg, hb;
    int c = 0;
    for (int k = 0; k < IC; k++) begin
      red_tdata[k*8 +: 8]   = src_byte(0, k);
      green_tdata[k*8 +: 8] = src_byte(1, k);
      blue_tdata[k*8 +: 8]  = src_byte(2, k);
    end
    red_tkeep = v.keep_r; green_tkeep = v.keep_g; blue_tkeep = v.keep_b;
    red_tlast = v.last_r; green_tlast = v.last_g; blue_tlast = v.last_b;
    red_tuser = user_of(gi); green_tuser = ~user_of(gi); blue_tuser = user_of(gi) ^ 128'hFF;
    red_tvalid = 1'b1; blue_tvalid = 1'b1; green_tvalid = (v.gdelay == 0);
    while (!(dr && dg && db) && c < 40) begin
      #1;
      chk($sformatf("g%0d_tvalid_collect", gi), rgb_tvalid, 1'b0);
      if (dr && !dg) chk($sformatf("g%0d_red_ready_held", gi), red_tready, 1'b0);
      if (db && !dg) chk($sformatf("g%0d_blue_ready_held", gi), blue_tready, 1'b0);
      hr = red_tvalid && red_tready;
      hg = green_tvalid && green_tready;
      hb = blue_tvalid && blue_tready;
      @(negedge axis_aclk);
      if (hr) begin dr = 1; red_tvalid = 1'b0; end
      if (hg) begin dg = 1; green_tvalid = 1'b0; end
      if (hb) begin db = 1; blue_tvalid = 1'b0; end
      c++;
      if (c >= v.gdelay && !dg) green_tvalid = 1'b1;
    end
    if (!(dr && dg && db)) chk($sformatf("g%0d_capture_timeout", gi), 1'b0, 1'b1);
    #1;
    chk($sformatf("g%0d_tvalid_one_cycle", gi), rgb_tvalid, 1'b1);
  endtask

  task automatic check_output(input vec_t v, input int gi, input int max_beats);
    logic [255:0] ed;
    logic [31:0]  ek;
    for (int b = 0; b < v.beats && b < max_beats; b++) begin
      exp_beat(v.n, b, ed, ek);
      chk($sformatf("g%0d_b%0d_tvalid", gi, b), rgb_tvalid, 1'b1);
      chk($sformatf("g%0d_b%0d_tdata", gi, b), rgb_tdata, ed);
      chk($sformatf("g%0d_b%0d_tkeep", gi, b), rgb_tkeep, ek);
      chk($sformatf("g%0d_b%0d_tuser", gi, b), rgb_tuser, user_of(gi));
      chk($sformatf("g%0d_b%0d_tlast", gi, b), rgb_tlast, (b == v.beats - 1) && v.tlast);
      chk($sformatf("g%0d_b%0d_readies", gi, b), {red_tready, green_tready, blue_tready}, 3'b000);
      if (b == v.beats - 1) chk($sformatf("g%0d_keep_final", gi), rgb_tkeep, v.keep_final);
      if (gi == 0 && b == 0) begin
        chk("full_b0_bytes0_3", rgb_tdata[31:0], 32'h0180_4000);
        chk("full_b0_byte31", rgb_tdata[255:248], 8'h4A);
      end
      if (gi == 0 && b == 1) chk("full_b1_byte0", rgb_tdata[7:0], 8'h8A);
      if (gi == 0 && b == 2) chk("full_b2_byte31", rgb_tdata[255:248], 8'h9F);
      if (b == v.bp_beat) begin
        rgb_tready = 1'b0;
        repeat (5) begin
          @(negedge axis_aclk); #1;
          chk($sformatf("g%0d_bp_tdata", gi), rgb_tdata, ed);
          chk($sformatf("g%0d_bp_tkeep", gi), rgb_tkeep, ek);
          chk($sformatf("g%0d_bp_tuser", gi), rgb_tuser, user_of(gi));
          chk($sformatf("g%0d_bp_tlast", gi), rgb_tlast, (b == v.beats - 1) && v.tlast);
          chk($sformatf("g%0d_bp_readies", gi), {red_tready, green_tready, blue_tready, rgb_tvalid}, 4'b0001);
        end
        rgb_tready = 1'b1;
      end
      @(negedge axis_aclk); #1;
    end
    if (max_beats >= v.beats) begin
      chk($sformatf("g%0d_tvalid_drop", gi), rgb_tvalid, 1'b0);
      chk($sformatf("g%0d_ready_return", gi), {red_tready, green_tready, blue_tready}, 3'b111);
      chk($sformatf("g%0d_mismatch", gi), channel_mismatch, v.mm);
    end
  endtask

  initial begin
    //        keep_r        keep_g        keep_b        lr lg lb gd bp  n  beats keep_final    tlast mm
    tbl[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0, 1, 32, 3, 32'hFFFF_FFFF, 0, 0};
    tbl[1] = '{32'h0000_001F, 32'h0000_001F, 32'h0000_001F, 1, 1, 1, 0, -1, 5, 1, 32'h0000_7FFF, 1, 0};
    tbl[2] = '{32'h0000_07FF, 32'h0000_07FF, 32'h0000_07FF, 1, 1, 1, 4, -1, 11, 2, 32'h0000_0001, 1, 0};
    tbl[3] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1, 1, 1, 0, -1, 0, 1, 32'h0000_0000, 1, 0};
    tbl[4] = '{32'hFFFF_00FF, 32'hFFFF_00FF, 32'hFFFF_00FF, 0, 0, 0, 2, 0, 8, 1, 32'h00FF_FFFF, 0, 0};
    tbl[5] = '{32'h0000_001F, 32'h0000_001F, 32'h0000_000F, 0, 0, 0, 0, -1, 5, 1, 32'h0000_7FFF, 0, 1};
    tbl[6] = '{32'h0000_001F, 32'h0000_001F, 32'h0000_001F, 0, 1, 1, 0, -1, 5, 1, 32'h0000_7FFF, 0, 1};

    red_tvalid = 1'b0; green_tvalid = 1'b0; blue_tvalid = 1'b0; rgb_tready = 1'b1;
    red_tdata = '0; green_tdata = '0; blue_tdata = '0;
    red_tkeep = '0; green_tkeep = '0; blue_tkeep = '0;
    red_tuser = '0; green_tuser = '0; blue_tuser = '0;
    red_tlast = 1'b0; green_tlast = 1'b0; blue_tlast = 1'b0;

    #1;
    chk("reset_readies", {red_tready, green_tready, blue_tready}, 3'b000);
    chk("reset_tvalid", rgb_tvalid, 1'b0);
    chk("reset_tlast", rgb_tlast, 1'b0);
    chk("reset_mismatch", channel_mismatch, 1'b0);
    repeat (3) @(negedge axis_aclk);
    axis_resetn = 1'b1;
    #1;
    chk("release_readies", {red_tready, green_tready, blue_tready}, 3'b111);

    for (int g = 0; g < 7; g++) begin
      send_group(tbl[g], g);
      check_output(tbl[g], g, 3);
    end

    // Abort a full group at beat1; mismatch is still set from earlier groups.
    send_group(tbl[0], 7);
    check_output(tbl[0], 7, 1);
    #1 axis_resetn = 1'b0;
    #1;
    chk("midemit_tvalid", rgb_tvalid, 1'b0);
    chk("midemit_tlast", rgb_tlast, 1'b0);
    chk("midemit_readies", {red_tready, green_tready, blue_tready}, 3'b000);
    chk("midemit_mismatch", channel_mismatch, 1'b0);
    repeat (2) @(negedge axis_aclk);
    axis_resetn = 1'b1;
    #1;
    chk("rerelease_readies", {red_tready, green_tready, blue_tready}, 3'b111);
    chk("rerelease_tvalid", rgb_tvalid, 1'b0);
    send_group(tbl[1], 8);
    check_output(tbl[1], 8, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/interleave_color_channels.md
INTERLEAVE_COLOR_CHANNELS -- requirements
Module: interleave_color_channels

Interface
REQ-001 SHALL have parameters: TDATA_WIDTH, default 256, data bus width; TKEEP_WIDTH, default TDATA_WIDTH/8, byte-keep width; TUSER_WIDTH, default 128, sideband width; ITEM_WIDTH, default 8, item width (multiple of 8).
REQ-002 SHALL derive ITEM_COUNT = TDATA_WIDTH/ITEM_WIDTH and KEEP_PER_ITEM = ITEM_WIDTH/8; channel count fixed at 3 (red=0, green=1, blue=2).
REQ-003 SHALL use one clock and an asynchronous, active-low reset: axis_aclk  in  1  clock; axis_resetn  in  1  async active-low reset.
REQ-004 SHALL have three input streams, X in {red, green, blue}: X_tdata in TDATA_WIDTH; X_tkeep in TKEEP_WIDTH; X_tuser in TUSER_WIDTH; X_tvalid in 1; X_tready out 1; X_tlast in 1.
REQ-005 SHALL have output stream: rgb_tdata out TDATA_WIDTH; rgb_tkeep out TKEEP_WIDTH; rgb_tuser out TUSER_WIDTH; rgb_tvalid out 1; rgb_tready in 1; rgb_tlast out 1.
REQ-006 SHALL have channel_mismatch  out  1, a sticky error flag.

Function
REQ-007 SHALL treat each input beat as n items of one channel; n = count of contiguous valid items from the LSB of tkeep, where an item is valid when its KEEP_PER_ITEM bits are set; n ranges 0..ITEM_COUNT.
REQ-008 SHALL, per group (one beat per channel), output interleaved item sequence i = 0..3n-1, where item i = item floor(i/3) of channel (i mod 3); item i goes to output beat floor(i/ITEM_COUNT), lane i mod ITEM_COUNT.
REQ-009 SHALL have states COLLECT and EMIT.
REQ-010 In COLLECT, X_tready SHALL equal NOT X_held; on an X handshake, the X beat is captured and X_held is set.
REQ-011 SHALL transition COLLECT->EMIT on the cycle all three X_held are set; beat counter = 0; rgb_tvalid rises the next cycle.
REQ-012 In EMIT, all X_tready SHALL be 0; rgb_tvalid = 1; outputs remain stable until rgb_tready.
REQ-013 SHALL have beats = max(1, ceil(3n/ITEM_COUNT)); on a handshake of beat counter < beats-1, the counter increments.
REQ-014 On a handshake of the final beat, SHALL clear all X_held and return to COLLECT; no bubble beyond one cycle of X_tready re-assertion.
REQ-015 SHALL drive rgb_tkeep item-lane bits set for lanes holding valid items, 0 otherwise; n=0 yields a single beat with rgb_tkeep=0.
REQ-016 SHALL assert rgb_tlast only on the final beat of a group, and only if red's captured tlast=1.
REQ-017 SHALL drive rgb_tuser with red's captured tuser on every beat of the group.
REQ-018 SHALL set channel_mismatch when the three captured n values differ, or the captured tlast values differ; red's n and tlast then govern; flag clears only on reset.
REQ-019 SHALL drive lanes without a valid item in rgb_tdata to 0.

Reset
REQ-020 On axis_resetn=0 (any state, including mid-EMIT), SHALL immediately clear: state=COLLECT, counter=0, X_held=0, rgb_tvalid=0, rgb_tlast=0, channel_mismatch=0; X_tready=0 while reset is held, 1 the first cycle after release.
REQ-021 SHALL discard a partially emitted group at reset; it is not resumed.

Structure
REQ-022 SHALL place ITEM_WIDTH default, channel indices, and state encoding in a shared package (bitmap_tensor_pkg).
REQ-023 SHALL implement one sub-module, interleave_channel_slot (capture register, held flag, n computation), instantiated three times; top holds FSM and output mux.

Verification
REQ-024 Full beats (256b): red=0x00..0x1F, green=0x40..0x5F, blue=0x80..0x9F, tlast=0 -> 3 beats, tkeep=all-ones; beat0 bytes 00,40,80,01,...; byte31=0x4A; beat1 byte0=0x8A; beat2 byte31=0x9F; tlast=0.
REQ-025 Partial beat: all tkeep=0x1F, tlast=1 -> one beat, tkeep=0x00007FFF, tlast=1, bytes 15..31 = 0; n=11 -> two beats, second tkeep=0x1, tlast on second only.
REQ-026 Skew: green valid 4 cycles after red/blue -> red/blue tready low after capture; rgb_tvalid rises exactly 1 cycle after green handshake.
REQ-027 Backpressure: rgb_tready low 5 cycles during beat1 -> tdata/tkeep/tuser/tlast unchanged; all X_tready stay 0.
REQ-028 Mismatch: blue tkeep=0x0F, red/green 0x1F -> channel_mismatch=1 and sticky; output per red n=5.
REQ-029 Reset asserted mid-EMIT at beat1 -> rgb_tvalid=0 asynchronously; after release X_tready=1, next group output correct from beat0.
